vend_dispense_ctrl: RTL and testbench

//  Sequences the vending machine's physical back end from the coin FSM's one-cycle vend

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_timer.sv | 41 ++++
 rtl/vend_dispense_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending back-end dispense controller.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMotor,
        StEject,
        StGap,
        StDone,
        StFault
    } state_t;

    typedef logic [2:0] nickel_t;

    localparam nickel_t     MAX_NICKELS = 3'd4;
    localparam int unsigned TMR_W       = 16;

    // Change codes above MAX_NICKELS are treated as a full MAX_NICKELS payout.
    function automatic nickel_t clamp_nickels(input nickel_t n);
        return (n > MAX_NICKELS) ? MAX_NICKELS : n;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Up-counter that restarts on every change of the tracked state code; flags when the
// cycles spent in the current state (counting the current one) reach i_limit.
module vend_timer
    import vend_pkg::*;
#(
    parameter int unsigned Width = TMR_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_state,
    input  logic [Width-1:0] i_limit,
    output logic             o_reached
);

    logic [2:0]       prev_q;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Entry cycle loads 1 so the count equals cycles spent in the state so far.
    always_comb begin
        cnt_d = cnt_q;
        if (i_state != prev_q) begin
            cnt_d = Width'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    assign o_reached = (cnt_d >= i_limit);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_q <= 3'd0;
            cnt_q  <= '0;
        end else begin
            prev_q <= i_state;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend back-end sequencer: motor, per-nickel change eject, one pending request, fault trap.
// Optional statistics counters are built when VEND_STATS_EN is defined.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_TMO = 100,
    parameter int unsigned EJECT_TMO = 20,
    parameter int unsigned PULSE_GAP = 2
`ifdef VEND_STATS_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_soda,
    input  logic [2:0]       i_change,
    input  logic             i_drop_sense,
    input  logic             i_eject_ack,
    input  logic             i_service_clr,
    output logic             o_motor,
    output logic             o_eject,
    output logic             o_busy,
    output logic             o_coin_block,
    output logic             o_vend_done,
    output logic             o_fault,
    output logic             o_overrun
`ifdef VEND_STATS_EN
    ,
    output logic [CNT_W-1:0] o_vend_cnt,
    output logic [CNT_W-1:0] o_nickel_cnt
`endif
);

    localparam logic [TMR_W-1:0] MOTOR_LIM = TMR_W'(MOTOR_TMO);
    localparam logic [TMR_W-1:0] EJECT_LIM = TMR_W'(EJECT_TMO);
    localparam logic [TMR_W-1:0] GAP_LIM   = TMR_W'(PULSE_GAP);

    state_t           state_q, state_d;
    logic             slot_full_q, slot_full_d;
    nickel_t          slot_chg_q, slot_chg_d;
    nickel_t          nick_q, nick_d;
    logic             overrun_q, overrun_d;
    logic             motor_q, eject_q, busy_q, done_q, fault_q;
    logic             launch_slot;
    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_reached;

    always_comb begin
        case (state_q)
            StMotor: tmr_limit = MOTOR_LIM;
            StEject: tmr_limit = EJECT_LIM;
            default: tmr_limit = GAP_LIM;
        endcase
    end

    vend_timer #(
        .Width (TMR_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_state   (state_q),
        .i_limit   (tmr_limit),
        .o_reached (tmr_reached)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (slot_full_q || i_soda) state_d = StMotor;
            end
            StMotor: begin
                if (i_drop_sense)     state_d = (nick_q != 3'd0) ? StEject : StDone;
                else if (tmr_reached) state_d = StFault;
            end
            StEject: begin
                if (i_eject_ack)      state_d = (nick_q == 3'd1) ? StDone : StGap;
                else if (tmr_reached) state_d = StFault;
            end
            StGap: begin
                if (tmr_reached) state_d = StEject;
            end
            StDone: begin
                state_d = slot_full_q ? StMotor : StIdle;
            end
            StFault: begin
                if (i_service_clr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending slot, change owed and overrun flag. A slot launched this cycle frees
    // room for a request arriving in the same cycle.
    always_comb begin
        slot_full_d = slot_full_q;
        slot_chg_d  = slot_chg_q;
        nick_d      = nick_q;
        overrun_d   = overrun_q;
        launch_slot = slot_full_q && (state_q == StIdle || state_q == StDone);

        if (launch_slot) begin
            nick_d      = slot_chg_q;
            slot_full_d = 1'b0;
        end

        if (i_soda) begin
            if (state_q == StFault) begin
                overrun_d = 1'b1;
            end else if (state_q == StIdle && !slot_full_q) begin
                nick_d = clamp_nickels(i_change);
            end else if (!slot_full_d) begin
                slot_full_d = 1'b1;
                slot_chg_d  = clamp_nickels(i_change);
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == StEject && i_eject_ack) nick_d = nick_q - 3'd1;
        if (state_q == StFault && i_service_clr) slot_full_d = 1'b0;
        if (i_service_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            slot_full_q <= 1'b0;
            slot_chg_q  <= '0;
            nick_q      <= '0;
            overrun_q   <= 1'b0;
            motor_q     <= 1'b0;
            eject_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            slot_chg_q  <= slot_chg_d;
            nick_q      <= nick_d;
            overrun_q   <= overrun_d;
            motor_q     <= (state_d == StMotor);
            eject_q     <= (state_d == StEject);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            fault_q     <= (state_d == StFault);
        end
    end

    assign o_motor      = motor_q;
    assign o_eject      = eject_q;
    assign o_busy       = busy_q;
    assign o_vend_done  = done_q;
    assign o_fault      = fault_q;
    assign o_overrun    = overrun_q;
    assign o_coin_block = slot_full_q | fault_q;

`ifdef VEND_STATS_EN
    logic [CNT_W-1:0] vend_cnt_q, nickel_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vend_cnt_q   <= '0;
            nickel_cnt_q <= '0;
        end else begin
            if (state_q == StDone) vend_cnt_q <= vend_cnt_q + CNT_W'(1);
            if (state_q == StEject && i_eject_ack) nickel_cnt_q <= nickel_cnt_q + CNT_W'(1);
        end
    end

    assign o_vend_cnt   = vend_cnt_q;
    assign o_nickel_cnt = nickel_cnt_q;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: vector table, directed corner cases and a
// randomized run scored against a transaction-level model of the pending queue.
module tb_vend_dispense_ctrl;

    localparam int MOTOR_TMO = 100;
    localparam int EJECT_TMO = 20;
    localparam int PULSE_GAP = 2;
    localparam int NREQ      = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soda = 1'b0;
    logic [2:0] change = 3'd0;
    logic       drop = 1'b0;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic       motor, eject, busy, coin_block, vend_done, fault, overrun;
`ifdef VEND_STATS_EN
    logic [15:0] vend_cnt, nickel_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vend_dispense_ctrl #(
        .MOTOR_TMO (MOTOR_TMO),
        .EJECT_TMO (EJECT_TMO),
        .PULSE_GAP (PULSE_GAP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_soda        (soda),
        .i_change      (change),
        .i_drop_sense  (drop),
        .i_eject_ack   (ack),
        .i_service_clr (clr),
        .o_motor       (motor),
        .o_eject       (eject),
        .o_busy        (busy),
        .o_coin_block  (coin_block),
        .o_vend_done   (vend_done),
        .o_fault       (fault),
        .o_overrun     (overrun)
`ifdef VEND_STATS_EN
        ,
        .o_vend_cnt    (vend_cnt),
        .o_nickel_cnt  (nickel_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs_vec();
        return {25'd0, motor, eject, busy, coin_block, vend_done, fault, overrun};
    endfunction

    // Issue one request and service it with the given sensor/ack latencies (0 = never).
    task automatic run_vend(input int chg, input int drop_dly, input int ack_dly,
                            output int motor_cyc, output int ejects, output int gap_min,
                            output int gap_max, output int done_cnt, output int faulted);
        int ecyc;
        int gcyc;
        bit seen;
        ecyc = 0; gcyc = 0; seen = 1'b0;
        motor_cyc = 0; ejects = 0; gap_min = 1000; gap_max = 0; done_cnt = 0; faulted = 0;
        soda = 1'b1; change = chg[2:0];
        step();
        soda = 1'b0;
        for (int cyc = 0; cyc < 400 && done_cnt == 0 && faulted == 0; cyc++) begin
            drop = 1'b0; ack = 1'b0;
            if (motor) begin
                motor_cyc++;
                if (motor_cyc == drop_dly) drop = 1'b1;
            end
            if (eject) begin
                if (ecyc == 0) begin
                    ejects++;
                    if (seen) begin
                        if (gcyc < gap_min) gap_min = gcyc;
                        if (gcyc > gap_max) gap_max = gcyc;
                    end
                end
                ecyc++; gcyc = 0; seen = 1'b1;
                if (ecyc == ack_dly) ack = 1'b1;
            end else begin
                ecyc = 0;
                if (seen) gcyc++;
            end
            if (vend_done) done_cnt++;
            if (fault) faulted = 1;
            step();
        end
        drop = 1'b0; ack = 1'b0;
    endtask

    // Immediate sensor/ack responses; returns while the done pulse is visible.
    task automatic respond(output int ejects, output int done);
        bit prev_e;
        prev_e = 1'b0; ejects = 0; done = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (vend_done) begin
                done = 1;
                break;
            end
            if (eject && !prev_e) ejects++;
            prev_e = eject;
            drop = motor; ack = eject;
            step();
            drop = 1'b0; ack = 1'b0;
        end
    endtask

    typedef struct {
        int chg;
        int drop_dly;
        int ack_dly;
        int exp_motor;
        int exp_ejects;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int mc, ej, gmin, gmax, dn, ft;
        int exp_vends, exp_nick;
        int q[$];
        int acks, m_age, m_dly, e_age, e_dly, issued, accepted, vends_done, c, exp_v;
        bit exp_ovr;

        tbl[0] = '{0, 5, 2, 5, 0};
        tbl[1] = '{3, 3, 2, 3, 3};
        tbl[2] = '{7, 2, 1, 2, 4};
        tbl[3] = '{4, 1, 3, 1, 4};
        tbl[4] = '{5, 4, 1, 4, 4};
        tbl[5] = '{1, 6, 4, 6, 1};
        exp_vends = 0; exp_nick = 0;

        step();
        step();
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        step();
        check("idle_outputs", outs_vec(), 0);

        foreach (tbl[i]) begin
            run_vend(tbl[i].chg, tbl[i].drop_dly, tbl[i].ack_dly, mc, ej, gmin, gmax, dn, ft);
            check($sformatf("vec%0d_motor_cycles", i), mc, tbl[i].exp_motor);
            check($sformatf("vec%0d_ejects", i), ej, tbl[i].exp_ejects);
            check($sformatf("vec%0d_done", i), dn, 1);
            check($sformatf("vec%0d_fault", i), ft, 0);
            if (tbl[i].exp_ejects >= 2) begin
                check($sformatf("vec%0d_gap_min", i), gmin, PULSE_GAP);
                check($sformatf("vec%0d_gap_max", i), gmax, PULSE_GAP);
            end
            check($sformatf("vec%0d_idle_after", i), busy, 0);
            exp_vends += 1;
            exp_nick  += tbl[i].exp_ejects;
`ifdef VEND_STATS_EN
            check($sformatf("vec%0d_vend_cnt", i), vend_cnt, exp_vends);
            check($sformatf("vec%0d_nickel_cnt", i), nickel_cnt, exp_nick);
`endif
        end

        // Pending slot and overrun while a vend is in progress.
        soda = 1'b1; change = 3'd1;
        step();
        soda = 1'b0;
        check("t3_motor_latency", motor, 1);
        check("t3_block_empty", coin_block, 0);
        soda = 1'b1; change = 3'd2;
        step();
        soda = 1'b0;
        check("t3_block_pending", coin_block, 1);
        check("t3_no_overrun_yet", overrun, 0);
        soda = 1'b1; change = 3'd0;
        step();
        soda = 1'b0;
        check("t3_overrun_set", overrun, 1);
        respond(ej, dn);
        check("t3_vend1_done", dn, 1);
        check("t3_vend1_ejects", ej, 1);
        step();
        check("t3_vend2_starts", motor, 1);
        check("t3_slot_freed", coin_block, 0);
        respond(ej, dn);
        check("t3_vend2_done", dn, 1);
        check("t3_vend2_ejects", ej, 2);
        step();
        check("t3_idle", busy, 0);
        check("t3_overrun_sticky", overrun, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t3_overrun_cleared", overrun, 0);

        // Motor timeout.
        soda = 1'b1; change = 3'd0;
        step();
        soda = 1'b0;
        mc = 0;
        while (motor && mc < 300) begin
            mc++;
            step();
        end
        check("t4_motor_cycles", mc, MOTOR_TMO);
        check("t4_fault", fault, 1);
        check("t4_block", coin_block, 1);
        check("t4_busy", busy, 1);
        soda = 1'b1; change = 3'd1;
        step();
        soda = 1'b0;
        check("t4_soda_ignored", motor, 0);
        check("t4_overrun", overrun, 1);
        check("t4_still_fault", fault, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t4_cleared", outs_vec(), 0);

        // Eject timeout.
        soda = 1'b1; change = 3'd1;
        step();
        soda = 1'b0;
        drop = 1'b1;
        step();
        drop = 1'b0;
        mc = 0;
        while (eject && mc < 100) begin
            mc++;
            step();
        end
        check("t5_eject_cycles", mc, EJECT_TMO);
        check("t5_fault", fault, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t5_cleared", fault, 0);

        // Reset mid-eject.
        soda = 1'b1; change = 3'd2;
        step();
        soda = 1'b0;
        drop = 1'b1;
        step();
        drop = 1'b0;
        check("t6_in_eject", eject, 1);
        rst_n = 1'b0;
        step();
        check("t6_reset_outputs", outs_vec(), 0);
`ifdef VEND_STATS_EN
        check("t6_vend_cnt", vend_cnt, 0);
        check("t6_nickel_cnt", nickel_cnt, 0);
`endif
        rst_n = 1'b1;
        step();
        check("t6_idle_after", outs_vec(), 0);

        // Randomized traffic against a queue model of accepted vends.
        acks = 0; m_age = 0; e_age = 0; issued = 0; accepted = 0; vends_done = 0;
        exp_ovr = 1'b0;
        m_dly = $urandom_range(1, 8);
        e_dly = $urandom_range(1, 6);
        for (int cyc = 0; cyc < 20000 && (issued < NREQ || q.size() > 0); cyc++) begin
            if (vend_done) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_done", 1, 0);
                end else begin
                    exp_v = q.pop_front();
                    check("rnd_ejects", acks, exp_v);
                end
                check("rnd_overrun", overrun, exp_ovr);
                acks = 0;
                vends_done++;
            end
            drop = 1'b0; ack = 1'b0;
            if (motor) begin
                m_age++;
                if (m_age >= m_dly) begin
                    drop = 1'b1;
                    m_dly = $urandom_range(1, 8);
                end
            end else begin
                m_age = 0;
            end
            if (eject) begin
                e_age++;
                if (e_age >= e_dly) begin
                    ack = 1'b1;
                    acks++;
                    e_dly = $urandom_range(1, 6);
                end
            end else begin
                e_age = 0;
            end
            soda = 1'b0;
            if (issued < NREQ && $urandom_range(0, 5) == 0) begin
                c = $urandom_range(0, 7);
                soda = 1'b1; change = c[2:0];
                issued++;
                if (q.size() < 2) begin
                    q.push_back((c > 4) ? 4 : c);
                    accepted++;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            step();
        end
        soda = 1'b0; drop = 1'b0; ack = 1'b0;
        check("rnd_queue_drained", q.size(), 0);
        check("rnd_vends", vends_done, accepted);
        check("rnd_no_fault", fault, 0);
        check("rnd_overrun_final", overrun, exp_ovr);
        check("rnd_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
